// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb: register-file writeback arbiter with a long-latency pending scoreboard
// Execute always wins; the divider overtakes the LSU once it has starved STARVE_LIMIT cycles.
module gpr_wb_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        div_valid_i,
    output logic        div_ready_o,
    input  logic [4:0]  div_waddr_i,
    input  logic [31:0] div_wdata_i,
    input  logic        sb_set_i,
    input  logic [4:0]  sb_rd_i,
    input  logic [4:0]  chk_raddr1_i,
    input  logic [4:0]  chk_raddr2_i,
    input  logic [4:0]  chk_waddr_i,
    output logic        hazard_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [31:0] pending_o
);
    logic [2:0]  starve, starve_n;
    logic        ex_eff, div_boost, lsu_acc, div_acc, win_we;
    logic [4:0]  win_addr;
    logic [31:0] win_data, clr, set, pend_n;

    always_comb begin
        ex_eff      = ex_we_i & (ex_waddr_i != 5'd0);
        div_boost   = starve >= 3'(STARVE_LIMIT);
        lsu_ready_o = ~ex_eff & ~(div_boost & div_valid_i);
        div_ready_o = ~ex_eff & (~lsu_valid_i | div_boost);
        lsu_acc     = lsu_valid_i & lsu_ready_o;
        div_acc     = div_valid_i & div_ready_o;
        // lsu_acc and div_acc are mutually exclusive, so one mux chain suffices
        win_addr    = ex_eff ? ex_waddr_i : lsu_acc ? lsu_waddr_i : div_waddr_i;
        win_data    = ex_eff ? ex_wdata_i : lsu_acc ? lsu_wdata_i : div_wdata_i;
        win_we      = ex_eff | (lsu_acc & |lsu_waddr_i) | (div_acc & |div_waddr_i);
        clr         = (lsu_acc ? 32'd1 << lsu_waddr_i : 32'd0) | (div_acc ? 32'd1 << div_waddr_i : 32'd0);
        set         = sb_set_i ? 32'd1 << sb_rd_i : 32'd0;
        pend_n      = ((pending_o & ~clr) | set) & 32'hFFFF_FFFE;
        starve_n    = (div_acc | ~div_valid_i) ? 3'd0 : (starve == 3'd7) ? 3'd7 : starve + 3'd1;
        hazard_o    = pending_o[chk_raddr1_i] | pending_o[chk_raddr2_i] | pending_o[chk_waddr_i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_o      <= 1'b0;
            waddr_o   <= 5'd0;
            wdata_o   <= 32'd0;
            pending_o <= 32'd0;
            starve    <= 3'd0;
        end else begin
            we_o      <= win_we;
            pending_o <= pend_n;
            starve    <= starve_n;
            if (win_we) begin
                waddr_o <= win_addr;
                wdata_o <= win_data;
            end
        end
    end
endmodule

// File: tb/tb_gpr_wb_arb.sv
// tb_gpr_wb_arb: directed and randomized checks of gpr_wb_arb against a behavioural model
module tb_gpr_wb_arb;
    localparam int LIMIT = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_we = 0, lsu_valid = 0, div_valid = 0, sb_set = 0;
    logic [4:0]  ex_waddr = 0, lsu_waddr = 0, div_waddr = 0, sb_rd = 0;
    logic [4:0]  r1 = 0, r2 = 0, wchk = 0;
    logic [31:0] ex_wdata = 0, lsu_wdata = 0, div_wdata = 0;
    logic        lsu_ready, div_ready, hazard, we;
    logic [4:0]  waddr;
    logic [31:0] wdata, pending;

    int tests = 0, fails = 0;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_pend;
    int          m_wait;
    logic        last_la, last_da;

    gpr_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .div_valid_i(div_valid), .div_ready_o(div_ready), .div_waddr_i(div_waddr), .div_wdata_i(div_wdata),
        .sb_set_i(sb_set), .sb_rd_i(sb_rd),
        .chk_raddr1_i(r1), .chk_raddr2_i(r2), .chk_waddr_i(wchk),
        .hazard_o(hazard), .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_we = 0; m_waddr = 0; m_wdata = 0; m_pend = 0; m_wait = 0;
        last_la = 0; last_da = 0;
    endtask

    // Called just after a falling edge with inputs set; returns just after the next falling edge.
    task automatic cycle();
        logic boost, exe, elr, edr, la, da, n_we;
        logic [4:0]  n_a;
        logic [31:0] n_d, n_p;
        #1;
        boost = (m_wait >= LIMIT);
        exe   = ex_we && ex_waddr != 0;
        elr   = !exe && !(boost && div_valid);
        edr   = !exe && (!lsu_valid || boost);
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, elr});
        check("div_ready", {31'd0, div_ready}, {31'd0, edr});
        check("hazard", {31'd0, hazard}, {31'd0, m_pend[r1] | m_pend[r2] | m_pend[wchk]});
        la = lsu_valid && elr;
        da = div_valid && edr;
        n_we = 0; n_a = m_waddr; n_d = m_wdata; n_p = m_pend;
        if (exe) begin n_we = 1; n_a = ex_waddr; n_d = ex_wdata; end
        else if (la && lsu_waddr != 0) begin n_we = 1; n_a = lsu_waddr; n_d = lsu_wdata; end
        else if (da && div_waddr != 0) begin n_we = 1; n_a = div_waddr; n_d = div_wdata; end
        if (la) n_p[lsu_waddr] = 1'b0;
        if (da) n_p[div_waddr] = 1'b0;
        if (sb_set) n_p[sb_rd] = 1'b1;
        n_p[0] = 1'b0;
        @(posedge clk);
        #1;
        m_we = n_we; m_waddr = n_a; m_wdata = n_d; m_pend = n_p;
        m_wait = (!div_valid || da) ? 0 : m_wait + 1;
        last_la = la; last_da = da;
        check("we", {31'd0, we}, {31'd0, m_we});
        check("waddr", {27'd0, waddr}, {27'd0, m_waddr});
        check("wdata", wdata, m_wdata);
        check("pending", pending, m_pend);
        @(negedge clk);
    endtask

    task automatic idle();
        ex_we = 0; lsu_valid = 0; div_valid = 0; sb_set = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_waddr", {27'd0, waddr}, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        rst_n = 1;

        // execute write appears next cycle for exactly one cycle
        ex_we = 1; ex_waddr = 5; ex_wdata = 32'hDEADBEEF;
        cycle();
        check("ex_wdata", wdata, 32'hDEADBEEF);
        idle();
        cycle();
        check("ex_one_shot", {31'd0, we}, 32'd0);

        // scoreboard set, hazard, then LSU clears it
        sb_set = 1; sb_rd = 10; r1 = 10;
        cycle();
        check("sb_set10", pending, 32'h400);
        check("hazard10", {31'd0, hazard}, 32'd1);
        sb_set = 0;
        cycle(); cycle();
        lsu_valid = 1; lsu_waddr = 10; lsu_wdata = 32'h1234;
        cycle();
        check("lsu_clear10", pending, 32'd0);
        check("lsu_wdata", wdata, 32'h1234);
        idle(); r1 = 0;

        // three-way collision resolves ex, lsu, div in order
        ex_we = 1; ex_waddr = 3; ex_wdata = 32'h33;
        lsu_valid = 1; lsu_waddr = 4; lsu_wdata = 32'h44;
        div_valid = 1; div_waddr = 6; div_wdata = 32'h66;
        cycle();
        check("order_x3", {27'd0, waddr}, 32'd3);
        ex_we = 0;
        cycle();
        check("order_x4", {27'd0, waddr}, 32'd4);
        lsu_valid = 0;
        cycle();
        check("order_x6", {27'd0, waddr}, 32'd6);
        idle();
        cycle();

        // starvation: divider waits LIMIT cycles behind continuous LSU traffic
        div_valid = 1; div_waddr = 9; div_wdata = 32'h99;
        lsu_valid = 1;
        for (int i = 0; i <= LIMIT; i++) begin
            lsu_waddr = 5'(i + 11); lsu_wdata = 32'(i + 32'h100);
            if (i == LIMIT) begin
                #1;
                check("starve_div_ready", {31'd0, div_ready}, 32'd1);
                check("starve_lsu_ready", {31'd0, lsu_ready}, 32'd0);
            end
            cycle();
        end
        idle();
        cycle();

        // divider completion racing a new issue to the same register keeps it pending
        div_valid = 1; div_waddr = 7; div_wdata = 32'h77; sb_set = 1; sb_rd = 7;
        cycle();
        check("div_x7_we", {31'd0, we}, 32'd1);
        check("set_wins", {31'd0, pending[7]}, 32'd1);
        idle();

        // x0 destinations are accepted but invisible
        lsu_valid = 1; lsu_waddr = 0; lsu_wdata = 32'hBAD; sb_set = 1; sb_rd = 0;
        #1;
        check("x0_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        cycle();
        check("x0_we", {31'd0, we}, 32'd0);
        idle();
        div_valid = 1; div_waddr = 7; div_wdata = 32'h70;
        cycle();
        idle();

        // randomized traffic obeying the hold-until-accepted rule
        for (int i = 0; i < 3000; i++) begin
            ex_we = ($urandom_range(0, 3) == 0);
            ex_waddr = 5'($urandom); ex_wdata = $urandom;
            if (!lsu_valid || last_la) begin
                lsu_valid = ($urandom_range(0, 1) == 1);
                lsu_waddr = 5'($urandom); lsu_wdata = $urandom;
            end
            if (!div_valid || last_da) begin
                div_valid = ($urandom_range(0, 2) == 0);
                div_waddr = 5'($urandom); div_wdata = $urandom;
            end
            sb_set = ($urandom_range(0, 2) == 0); sb_rd = 5'($urandom);
            r1 = 5'($urandom); r2 = 5'($urandom); wchk = 5'($urandom);
            cycle();
        end
        idle(); r1 = 0; r2 = 0; wchk = 0;
        cycle();

        // fill the scoreboard, then reset asynchronously with a write in flight
        for (int i = 1; i < 32; i++) begin
            sb_set = 1; sb_rd = 5'(i);
            cycle();
        end
        sb_set = 0;
        ex_we = 1; ex_waddr = 2; ex_wdata = 32'h22;
        cycle();
        check("full_pending", pending, 32'hFFFF_FFFE);
        idle();
        rst_n = 0;
        #1;
        check("async_pending", pending, 32'd0);
        check("async_we", {31'd0, we}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
